// File: rtl/life_engine.sv
// Conway B3/S23 cellular automaton core with cell-by-cell programming, run/pause/step
// control, generation counting and extinction/stability detection.
module life_engine #(
   parameter int ROWS      = 8,
   parameter int COLS      = 8,
   parameter int WRAP      = 1,
   parameter int PERIOD    = 4,
   parameter int GEN_W     = 16,
   parameter int AUTO_HALT = 1
) (
   input  logic                            clka,
   input  logic                            rst_n,
   input  logic                            stop,
   input  logic                            prgm,
   input  logic                            pp,
   input  logic                            step,
   input  logic                            btn0,
   input  logic                            btn1,
   output logic [1:0]                      game_state,
   output logic [ROWS*COLS-1:0]            grid,
   output logic [$clog2(ROWS*COLS)-1:0]    cursor,
   output logic [GEN_W-1:0]                gen_count,
   output logic                            extinct,
   output logic                            stable
);

   // state     | meaning
   // S_IDLE    | cleared, waiting for prgm or pp
   // S_PROGRAM | btn0 toggles the cell under the cursor, btn1 moves the cursor
   // S_RUN     | one generation every PERIOD cycles
   // S_PAUSE   | frozen; step advances exactly one generation

   localparam int N  = ROWS * COLS;
   localparam int CW = $clog2(N);
   localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_PROGRAM = 2'b01,
      S_RUN     = 2'b10,
      S_PAUSE   = 2'b11
   } state_t;

   state_t         state, state_nx;
   logic [5:0]     cmd_raw, cmd_s, cmd_h, cmd_fire;
   logic           f_stop, f_prgm, f_pp, f_step, f_btn0, f_btn1;
   logic [N-1:0]   next_grid;
   logic [TW-1:0]  tick;
   logic           tick_tc, halt_cond;
   logic           do_clear, do_update, do_toggle, do_adv, tick_run;

   assign cmd_raw = {stop, prgm, pp, step, btn0, btn1};

   always_ff @(posedge clka) begin
      if (!rst_n) begin
         cmd_s <= '0;
         cmd_h <= '0;
      end else begin
         cmd_s <= cmd_raw;
         cmd_h <= cmd_s;
      end
   end

   assign cmd_fire = cmd_s & ~cmd_h;

   // Only the highest-priority firing command survives; the rest are dropped.
   assign f_stop = cmd_fire[5];
   assign f_prgm = cmd_fire[4] & ~cmd_fire[5];
   assign f_pp   = cmd_fire[3] & ~|cmd_fire[5:4];
   assign f_step = cmd_fire[2] & ~|cmd_fire[5:3];
   assign f_btn0 = cmd_fire[1] & ~|cmd_fire[5:2];
   assign f_btn1 = cmd_fire[0] & ~|cmd_fire[5:1];

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         localparam int RU = (r == 0) ? ROWS - 1 : r - 1;
         localparam int RD = (r == ROWS - 1) ? 0 : r + 1;
         localparam int CL = (c == 0) ? COLS - 1 : c - 1;
         localparam int CR = (c == COLS - 1) ? 0 : c + 1;
         localparam bit VU = (WRAP != 0) || (r > 0);
         localparam bit VD = (WRAP != 0) || (r < ROWS - 1);
         localparam bit VL = (WRAP != 0) || (c > 0);
         localparam bit VR = (WRAP != 0) || (c < COLS - 1);

         logic [7:0] nb;
         logic [3:0] cnt;

         assign nb = {(VU && VL) ? grid[RU*COLS+CL] : 1'b0,
                      VU         ? grid[RU*COLS+c]  : 1'b0,
                      (VU && VR) ? grid[RU*COLS+CR] : 1'b0,
                      VL         ? grid[r*COLS+CL]  : 1'b0,
                      VR         ? grid[r*COLS+CR]  : 1'b0,
                      (VD && VL) ? grid[RD*COLS+CL] : 1'b0,
                      VD         ? grid[RD*COLS+c]  : 1'b0,
                      (VD && VR) ? grid[RD*COLS+CR] : 1'b0};
         assign cnt = 4'($countones(nb));
         assign next_grid[r*COLS+c] = (cnt == 4'd3) || (grid[r*COLS+c] && (cnt == 4'd2));
      end
   end

   assign tick_tc   = (tick == TW'(PERIOD - 1));
   assign halt_cond = (next_grid == '0) || (next_grid == grid);

   always_ff @(posedge clka) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      do_clear  = 1'b0;
      do_update = 1'b0;
      do_toggle = 1'b0;
      do_adv    = 1'b0;
      tick_run  = 1'b0;
      if (f_stop) begin
         state_nx = S_IDLE;
         do_clear = 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (f_prgm)    state_nx = S_PROGRAM;
               else if (f_pp) state_nx = S_RUN;
            end
            S_PROGRAM: begin
               if (f_pp)        state_nx  = S_RUN;
               else if (f_btn0) do_toggle = 1'b1;
               else if (f_btn1) do_adv    = 1'b1;
            end
            S_RUN: begin
               // A terminal-count update is never lost to a same-cycle state change.
               do_update = tick_tc;
               if (f_prgm)    state_nx = S_PROGRAM;
               else if (f_pp) state_nx = S_PAUSE;
               else if (tick_tc && (AUTO_HALT != 0) && halt_cond) state_nx = S_PAUSE;
               else           tick_run = 1'b1;
            end
            S_PAUSE: begin
               if (f_prgm)      state_nx  = S_PROGRAM;
               else if (f_pp)   state_nx  = S_RUN;
               else if (f_step) do_update = 1'b1;
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clka) begin
      if (!rst_n) begin
         grid      <= '0;
         cursor    <= '0;
         gen_count <= '0;
         stable    <= 1'b0;
         tick      <= '0;
      end else begin
         if (do_clear) begin
            grid      <= '0;
            cursor    <= '0;
            gen_count <= '0;
            stable    <= 1'b0;
         end else begin
            if (do_update) begin
               grid   <= next_grid;
               stable <= (next_grid == grid);
               if (gen_count != '1) gen_count <= gen_count + 1'b1;
            end
            if (do_toggle) begin
               grid   <= grid ^ (N'(1) << cursor);
               stable <= 1'b0;
            end
            if (do_adv) cursor <= (cursor == CW'(N - 1)) ? '0 : cursor + 1'b1;
         end
         tick <= tick_run ? (tick_tc ? '0 : tick + 1'b1) : '0;
      end
   end

   assign game_state = state;
   assign extinct    = (grid == '0);

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine: a command/response table on an 8x8 torus plus
// hand sequences for blinkers, gliders, auto-halt, saturation and reset.
module tb_life_engine;

   localparam logic [5:0] C_STOP = 6'b100000;
   localparam logic [5:0] C_PRGM = 6'b010000;
   localparam logic [5:0] C_PP   = 6'b001000;
   localparam logic [5:0] C_STEP = 6'b000100;
   localparam logic [5:0] C_BTN0 = 6'b000010;
   localparam logic [5:0] C_BTN1 = 6'b000001;

   logic       clka = 1'b0;
   logic       rst_n;
   logic [5:0] cmd;
   logic       stop, prgm, pp, step, btn0, btn1;
   int         n_cmp = 0;
   int         n_bad = 0;

   assign {stop, prgm, pp, step, btn0, btn1} = cmd;

   always #5 clka = ~clka;

   logic [1:0]  st8;  logic [63:0] g8;  logic [5:0] cur8;  logic [15:0] gen8;
   logic        ext8, stb8;
   logic [1:0]  st40; logic [15:0] g40; logic [3:0] cur40; logic [15:0] gen40;
   logic        ext40, stb40;
   logic [1:0]  st41; logic [15:0] g41; logic [3:0] cur41; logic [15:0] gen41;
   logic        ext41, stb41;
   logic [1:0]  st3;  logic [8:0]  g3;  logic [3:0] cur3;  logic [2:0]  gen3;
   logic        ext3, stb3;

   life_engine u8 (
      .clka(clka), .rst_n(rst_n), .stop(stop), .prgm(prgm), .pp(pp), .step(step),
      .btn0(btn0), .btn1(btn1), .game_state(st8), .grid(g8), .cursor(cur8),
      .gen_count(gen8), .extinct(ext8), .stable(stb8));

   life_engine #(.ROWS(4), .COLS(4), .WRAP(0), .PERIOD(1)) u4w0 (
      .clka(clka), .rst_n(rst_n), .stop(stop), .prgm(prgm), .pp(pp), .step(step),
      .btn0(btn0), .btn1(btn1), .game_state(st40), .grid(g40), .cursor(cur40),
      .gen_count(gen40), .extinct(ext40), .stable(stb40));

   life_engine #(.ROWS(4), .COLS(4), .WRAP(1), .PERIOD(1)) u4w1 (
      .clka(clka), .rst_n(rst_n), .stop(stop), .prgm(prgm), .pp(pp), .step(step),
      .btn0(btn0), .btn1(btn1), .game_state(st41), .grid(g41), .cursor(cur41),
      .gen_count(gen41), .extinct(ext41), .stable(stb41));

   life_engine #(.ROWS(3), .COLS(3), .WRAP(0), .PERIOD(1), .GEN_W(3), .AUTO_HALT(0)) u3 (
      .clka(clka), .rst_n(rst_n), .stop(stop), .prgm(prgm), .pp(pp), .step(step),
      .btn0(btn0), .btn1(btn1), .game_state(st3), .grid(g3), .cursor(cur3),
      .gen_count(gen3), .extinct(ext3), .stable(stb3));

   typedef struct packed {
      logic [5:0]  cmd;
      logic [1:0]  st;
      logic [5:0]  cur;
      logic [63:0] g;
      logic [15:0] gen;
   } vec_t;

   vec_t tbl [17];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic pulse(input logic [5:0] c);
      cmd = c;
      @(posedge clka); #1;
      cmd = '0;
      @(posedge clka); #1;
   endtask

   task automatic adv(input int n);
      for (int i = 0; i < n; i++) pulse(C_BTN1);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clka);
      #1;
   endtask

   initial begin
      cmd   = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clka);
      #1 rst_n = 1'b1;

      chk("reset.state",   64'(st8),  64'h0);
      chk("reset.grid",    g8,        64'h0);
      chk("reset.cursor",  64'(cur8), 64'h0);
      chk("reset.gen",     64'(gen8), 64'h0);
      chk("reset.stable",  64'(stb8), 64'h0);
      chk("reset.extinct", 64'(ext8), 64'h1);

      //          command          state  cursor grid     gen
      tbl[0]  = '{C_PRGM,          2'b01, 6'd0, 64'h0, 16'd0};
      tbl[1]  = '{C_BTN0,          2'b01, 6'd0, 64'h1, 16'd0};
      tbl[2]  = '{C_BTN1,          2'b01, 6'd1, 64'h1, 16'd0};
      tbl[3]  = '{C_BTN0,          2'b01, 6'd1, 64'h3, 16'd0};
      tbl[4]  = '{C_STEP,          2'b01, 6'd1, 64'h3, 16'd0};
      tbl[5]  = '{C_BTN0 | C_BTN1, 2'b01, 6'd1, 64'h1, 16'd0};
      tbl[6]  = '{C_BTN1,          2'b01, 6'd2, 64'h1, 16'd0};
      tbl[7]  = '{C_PP | C_BTN0,   2'b10, 6'd2, 64'h1, 16'd0};
      tbl[8]  = '{C_PRGM | C_PP,   2'b01, 6'd2, 64'h1, 16'd0};
      tbl[9]  = '{C_STOP | C_PRGM, 2'b00, 6'd0, 64'h0, 16'd0};
      tbl[10] = '{C_STEP,          2'b00, 6'd0, 64'h0, 16'd0};
      tbl[11] = '{C_BTN0,          2'b00, 6'd0, 64'h0, 16'd0};
      tbl[12] = '{C_PP,            2'b10, 6'd0, 64'h0, 16'd0};
      tbl[13] = '{C_PP,            2'b11, 6'd0, 64'h0, 16'd0};
      tbl[14] = '{C_STEP,          2'b11, 6'd0, 64'h0, 16'd1};
      tbl[15] = '{C_PRGM,          2'b01, 6'd0, 64'h0, 16'd1};
      tbl[16] = '{C_STOP,          2'b00, 6'd0, 64'h0, 16'd0};

      for (int i = 0; i < 17; i++) begin
         pulse(tbl[i].cmd);
         chk($sformatf("vec%0d.state", i),  64'(st8),  64'(tbl[i].st));
         chk($sformatf("vec%0d.cursor", i), 64'(cur8), 64'(tbl[i].cur));
         chk($sformatf("vec%0d.grid", i),   g8,        tbl[i].g);
         chk($sformatf("vec%0d.gen", i),    64'(gen8), 64'(tbl[i].gen));
      end

      // Blinker on the 8x8 torus, then pp landing on a terminal-count edge.
      pulse(C_PRGM);
      adv(9);  pulse(C_BTN0);
      adv(1);  pulse(C_BTN0);
      adv(1);  pulse(C_BTN0);
      chk("blink.programmed", g8, 64'hE00);
      pulse(C_PP);
      cycles(3);
      chk("blink.pre.grid", g8, 64'hE00);
      chk("blink.pre.gen",  64'(gen8), 64'd0);
      cycles(1);
      chk("blink.g1.grid", g8, 64'h40404);
      chk("blink.g1.gen",  64'(gen8), 64'd1);
      cycles(4);
      chk("blink.g2.grid",  g8, 64'hE00);
      chk("blink.g2.gen",   64'(gen8), 64'd2);
      chk("blink.g2.state", 64'(st8), 64'h2);
      cycles(2);
      cmd = C_PP;
      @(posedge clka); #1;
      cmd = '0;
      @(posedge clka); #1;
      chk("pp_at_tc.state", 64'(st8), 64'h3);
      chk("pp_at_tc.gen",   64'(gen8), 64'd3);
      chk("pp_at_tc.grid",  g8, 64'h40404);
      pulse(C_PP);
      chk("resume.state", 64'(st8), 64'h2);
      pulse(C_STOP | C_PP);
      chk("stop_pp.state", 64'(st8), 64'h0);
      chk("stop_pp.grid",  g8, 64'h0);
      chk("stop_pp.gen",   64'(gen8), 64'd0);

      // Lone cell dies, auto-halt pauses, step still counts.
      pulse(C_PRGM);
      pulse(C_BTN0);
      pulse(C_PP);
      cycles(3);
      chk("lone.pre.state", 64'(st8), 64'h2);
      chk("lone.pre.grid",  g8, 64'h1);
      cycles(1);
      chk("lone.grid",    g8, 64'h0);
      chk("lone.extinct", 64'(ext8), 64'h1);
      chk("lone.state",   64'(st8), 64'h3);
      chk("lone.gen",     64'(gen8), 64'd1);
      pulse(C_STEP);
      chk("lone.step.gen",   64'(gen8), 64'd2);
      chk("lone.step.grid",  g8, 64'h0);
      chk("lone.step.state", 64'(st8), 64'h3);
      pulse(C_STOP);

      // Held btn1 advances the cursor once.
      pulse(C_PRGM);
      cmd = C_BTN1;
      cycles(10);
      cmd = '0;
      cycles(2);
      chk("held_btn1.cursor", 64'(cur8), 64'd1);
      pulse(C_STOP);

      // Glider on 4x4: dead edges settle into a block, torus keeps going.
      pulse(C_PRGM);
      adv(1); pulse(C_BTN0);
      adv(5); pulse(C_BTN0);
      adv(2); pulse(C_BTN0);
      adv(1); pulse(C_BTN0);
      adv(1); pulse(C_BTN0);
      chk("glider.programmed", 64'(g40), 64'h0742);
      pulse(C_PP);
      cycles(4);
      chk("glider_w0.g4.grid", 64'(g40), 64'hE840);
      chk("glider_w0.g4.gen",  64'(gen40), 64'd4);
      cycles(4);
      chk("glider_w0.grid",   64'(g40), 64'hCC00);
      chk("glider_w0.stable", 64'(stb40), 64'h1);
      chk("glider_w0.state",  64'(st40), 64'h3);
      chk("glider_w0.gen",    64'(gen40), 64'd8);
      chk("glider_w1.extinct", 64'(ext41), 64'h0);
      chk("glider_w1.state",   64'(st41), 64'h2);
      chk("glider_w1.gen",     64'(gen41), 64'd8);
      pulse(C_STOP);

      // 3x3 blinker, 3-bit generation counter saturates at 7.
      pulse(C_PRGM);
      adv(3); pulse(C_BTN0);
      adv(1); pulse(C_BTN0);
      adv(1); pulse(C_BTN0);
      pulse(C_PP);
      cycles(1);
      chk("sat.g1.grid", 64'(g3), 64'h092);
      chk("sat.g1.gen",  64'(gen3), 64'd1);
      cycles(6);
      chk("sat.g7.grid", 64'(g3), 64'h092);
      chk("sat.g7.gen",  64'(gen3), 64'd7);
      cycles(3);
      chk("sat.g10.grid", 64'(g3), 64'h038);
      chk("sat.g10.gen",  64'(gen3), 64'd7);
      cycles(1);
      chk("sat.g11.grid", 64'(g3), 64'h092);
      chk("sat.g11.gen",  64'(gen3), 64'd7);
      pulse(C_STOP);

      // Reset beats concurrent commands, mid-RUN and mid-PROGRAM.
      pulse(C_PRGM);
      pulse(C_BTN0);
      pulse(C_PP);
      cmd   = C_PRGM | C_BTN0;
      rst_n = 1'b0;
      cycles(2);
      chk("rst_run.state", 64'(st8), 64'h0);
      chk("rst_run.grid",  g8, 64'h0);
      cmd   = '0;
      rst_n = 1'b1;
      pulse(C_PRGM);
      cmd   = C_PP;
      rst_n = 1'b0;
      cycles(2);
      cmd   = '0;
      rst_n = 1'b1;
      cycles(2);
      chk("rst_prog.state", 64'(st8), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
